fir_mc_engine: RTL and testbench
================================

# fir_mc_engine

Parametrised multi-channel FIR compute engine, the next generation of the FIR core in the FIR accelerator. One start runs a batch of C channels × N samples × T taps. Coefficients come from a per-channel coefficient bank. Input samples are read from, and results written to, channel-packed sample and result memories. Each output is rounded, shifted and saturated, with sticky saturation and configuration-error reporting back to the APB register block.

## Interface
- DATA_W, 16: sample/result width, signed two's complement
- COEF_W, 16: coefficient width, signed
- MAX_TAPS, 32: maximum taps per channel
- MAX_CH, 4: maximum channel count
- ADDR_W, 13: sample/result memory address width
- Derived: TAP_W=$clog2(MAX_TAPS+1), CH_W=$clog2(MAX_CH+1), CA_W=$clog2(MAX_CH*MAX_TAPS), ACC_W=DATA_W+COEF_W+$clog2(MAX_TAPS)

Ports:
- clk  in  1  single clock; one clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  batch request, accepted only in IDLE
- cfg_taps  in  TAP_W  T, taps per channel
- cfg_samples  in  ADDR_W+1  N, outputs per channel
- cfg_channels  in  CH_W  C, channel count
- cfg_shift  in  6  right shift applied to accumulator
- coef_addr  out  CA_W  c*MAX_TAPS + k
- coef_rdata  in  COEF_W  coefficient, valid 1 cycle after coef_addr
- smp_addr  out  ADDR_W  c*N + (n-k)
- smp_rdata  in  DATA_W  sample, valid 1 cycle after smp_addr
- res_addr  out  ADDR_W  c*N + n
- res_wdata  out  DATA_W  result
- res_we  out  1  result write strobe, 1 cycle per output
- busy  out  1  batch in progress
- done  out  1  1-cycle pulse at batch end
- err  out  1  config error, valid with done, held until next accept
- sat  out  1  sticky: any output saturated this batch

## Operation
- Config is captured at start accept. Later changes to cfg_* have no effect until the next batch.
- Error check at accept: T==0, T>MAX_TAPS, N==0, C==0, C>MAX_CH, or C*N>2^ADDR_W. On error, go to ERR for 1 cycle, pulse done with err=1, issue no memory accesses.
- Output definition: y_c[n] = sat(round(Σ_{k=0}^{T-1} h_c[k]·x_c[n-k]) >>> shift).
- Terms with n-k<0 contribute zero. Their addresses are still issued (smp_addr=c*N), but the product is masked.
- Rounding: if shift>0, add 2^(shift-1) before the arithmetic shift (round half up).
- Saturation: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and set sat.
- Order: channel-major (c outer, n middle, k inner, k ascending).
- FSM states:
  - IDLE → CHECK on start.
  - CHECK → ERR or MAC.
  - MAC issues k=0..T-1, one address pair per cycle, then → DRAIN.
  - DRAIN lasts 2 cycles (memory read, product register), then → WRITE.
  - WRITE → MAC for the next n/c, or → DONE after the last output.
  - DONE → IDLE.
  - ERR → IDLE.
- Accumulator: ACC_W signed, cleared at the first accumulate of each output; no internal overflow is possible.
- start while busy is ignored.
- rst in any state: return to IDLE, no further res_we, all outputs to their reset values.

## Timing
- Reset values: coef_addr, smp_addr, res_addr, res_wdata, res_we, busy, done, err, sat all 0.
- Cycle 0 is the start accept cycle. CHECK occupies cycle 0; busy is high from cycle 1.
- Per output: T issue + 2 drain + 1 write = T+3 cycles.
- res_we for global output j (j = c*N + n) is asserted in cycle (j+1)(T+3).
- done pulses in cycle C·N·(T+3)+1. busy falls in that same cycle.
- Error path: done=1, err=1 in cycle 1; busy stays 0.
- sat and err clear at the next accepted start.

## Structure
- Package fir_pkg: state enum, ACC_W/CA_W width functions, saturation-limit constants.
- Sub-module fir_round_sat: combinational round + shift + saturate. Inputs are the ACC_W accumulator and the shift; outputs are DATA_W data and a sat flag.
- Top contains the FSM, the c/n/k counters, the address generation, the 2-stage valid/mask pipeline and the accumulator.

## Test plan
- Impulse response: T=4, h0={1,2,3,4}, N=6, x={1,0,0,0,0,0}, shift 0, C=1 → y={1,2,3,4,0,0} at res_addr 0..5; res_we in cycles 7,14,…,42; done in cycle 43.
- Two channels: C=2, N=3, T=2, h0={1,1}, h1={1,-1}, x={1,2,3,5,7,4} → res addr 0..5 = {1,3,5,5,2,-3}.
- Rounding: T=1, h=0x4000, shift 15, x={3,-3} → y={2,-1}, sat=0.
- Saturation: T=2, h={0x7FFF,0x7FFF}, x={0x7FFF,0x7FFF}, shift 0 → y={0x7FFF,0x7FFF}, sat=1 after done, cleared at next start.
- Config errors: T=0, then C=MAX_CH+1, then C=4 with N=4096 (C·N > 2^ADDR_W) → each gives done=err=1 in cycle 1, no res_we, busy stays 0.
- Reset and re-entry: assert rst in cycle 10 of the impulse test → all outputs 0 the next cycle, no further res_we. A start during busy is ignored, and a new start afterwards completes the full batch correctly.

Source files
------------

// File: rtl/fir_mc_engine_pkg.sv
// Shared definitions for the multi-channel FIR engine: FSM state codes,
// derived-width helpers and default saturation limits.
// No ports; imported by the interface, the top and the round/saturate stage.
package fir_pkg;

   // FSM state encoding
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_MAC   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_ERR   = 3'd6;

   // Accumulator width: full product plus growth for MAX_TAPS terms.
   function automatic int acc_width(input int dw, input int cw, input int mt);
      return dw + cw + $clog2(mt);
   endfunction

   // Coefficient bank address width.
   function automatic int ca_width(input int mch, input int mt);
      return $clog2(mch * mt);
   endfunction

   // Output clamp limits for the default 16-bit data path.
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_SAT_MAX = (2 ** (DEF_DATA_W - 1)) - 1;
   localparam int DEF_SAT_MIN = -(2 ** (DEF_DATA_W - 1));

endpackage

// File: rtl/fir_mc_engine_if.sv
// Bundle of start/config, coefficient/sample read ports, result write port
// and status signals of the FIR engine. master = engine, slave = host/memories.
// Read data is expected one cycle after the address; no backpressure.
interface fir_mc_engine_if
   import fir_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int COEF_W   = 16,
   parameter int MAX_TAPS = 32,
   parameter int MAX_CH   = 4,
   parameter int ADDR_W   = 13
);
   localparam int TAP_W = $clog2(MAX_TAPS + 1);
   localparam int CH_W  = $clog2(MAX_CH + 1);
   localparam int CA_W  = ca_width(MAX_CH, MAX_TAPS);

   logic                     start;
   logic [TAP_W-1:0]         cfg_taps;
   logic [ADDR_W:0]          cfg_samples;
   logic [CH_W-1:0]          cfg_channels;
   logic [5:0]               cfg_shift;
   logic [CA_W-1:0]          coef_addr;
   logic signed [COEF_W-1:0] coef_rdata;
   logic [ADDR_W-1:0]        smp_addr;
   logic signed [DATA_W-1:0] smp_rdata;
   logic [ADDR_W-1:0]        res_addr;
   logic signed [DATA_W-1:0] res_wdata;
   logic                     res_we;
   logic                     busy;
   logic                     done;
   logic                     err;
   logic                     sat;

   modport master (
      input  start, cfg_taps, cfg_samples, cfg_channels, cfg_shift,
      input  coef_rdata, smp_rdata,
      output coef_addr, smp_addr, res_addr, res_wdata, res_we,
      output busy, done, err, sat
   );

   modport slave (
      output start, cfg_taps, cfg_samples, cfg_channels, cfg_shift,
      output coef_rdata, smp_rdata,
      input  coef_addr, smp_addr, res_addr, res_wdata, res_we,
      input  busy, done, err, sat
   );

endinterface

// File: rtl/fir_mc_engine_round_sat.sv
// Round-half-up, arithmetic right shift and clamp of the accumulator to DATA_W.
// Purely combinational (zero latency); no handshake.
// Ports: acc/shift in, dout (clamped result) and sat (clamp occurred) out.
module fir_round_sat
   import fir_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 37
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  logic [5:0]               shift,
   output logic signed [DATA_W-1:0] dout,
   output logic                     sat
);
   // One guard bit so acc + 2^(shift-1) cannot wrap.
   localparam int SW = ACC_W + 1;
   localparam logic signed [SW-1:0] MAX_V = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

   logic signed [SW-1:0] ext, half, shf;

   always_comb begin
      ext  = {acc[ACC_W-1], acc};
      half = '0;
      if (shift != 6'd0) half = SW'(1) << (shift - 6'd1);
      // Beyond ACC_W the rounded quotient is always zero.
      if (shift > 6'(ACC_W)) shf = '0;
      else                   shf = (ext + half) >>> shift;
      sat = 1'b1;
      if (shf > MAX_V)      dout = MAX_V[DATA_W-1:0];
      else if (shf < MIN_V) dout = MIN_V[DATA_W-1:0];
      else begin
         dout = shf[DATA_W-1:0];
         sat  = 1'b0;
      end
   end

endmodule

// File: rtl/fir_mc_engine.sv
// Multi-channel FIR batch engine: C channels x N outputs x T taps, one MAC per cycle.
// Latency T+3 cycles per output (T issue, 2 drain, 1 write); done at C*N*(T+3)+1.
// No backpressure: memories answer in fixed 1 cycle; start ignored while busy.
// Ports: clk, rst (sync, active-high), bus = fir_mc_engine_if.master.
module fir_mc_engine
   import fir_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int COEF_W   = 16,
   parameter int MAX_TAPS = 32,
   parameter int MAX_CH   = 4,
   parameter int ADDR_W   = 13
) (
   input logic            clk,
   input logic            rst,
   fir_mc_engine_if.master bus
);
   localparam int TAP_W = $clog2(MAX_TAPS + 1);
   localparam int CH_W  = $clog2(MAX_CH + 1);
   localparam int CA_W  = ca_width(MAX_CH, MAX_TAPS);
   localparam int ACC_W = acc_width(DATA_W, COEF_W, MAX_TAPS);
   localparam int PRD_W = DATA_W + COEF_W;
   localparam int CN_W  = CH_W + ADDR_W + 1;

   logic [2:0]               state;
   logic [TAP_W-1:0]         t_r, k_cnt;
   logic [ADDR_W:0]          n_r;
   logic [CH_W-1:0]          c_r, c_cnt;
   logic [5:0]               sh_r;
   logic [ADDR_W-1:0]        n_cnt, smp_base, res_ptr;
   logic [CA_W-1:0]          coef_base;
   logic                     drain_cnt;
   logic                     p1_vld, p1_mask, p1_first, p2_vld, p2_first;
   logic signed [PRD_W-1:0]  prod;
   logic signed [ACC_W-1:0]  acc;
   logic                     err_r, sat_r;

   logic [CN_W-1:0]          cn_prod;
   logic                     cfg_bad, last_k, last_n, last_c, in_mac, mask;
   logic [ADDR_W-1:0]        k_ext, smp_off;
   logic signed [DATA_W-1:0] rs_dout;
   logic                     rs_sat;

   // Config validity, evaluated in CHECK on the captured copy.
   assign cn_prod = {{(ADDR_W+1){1'b0}}, c_r} * {{CH_W{1'b0}}, n_r};
   assign cfg_bad = (t_r == '0) || (t_r > TAP_W'(MAX_TAPS)) || (n_r == '0) ||
                    (c_r == '0) || (c_r > CH_W'(MAX_CH)) ||
                    (cn_prod > CN_W'(2 ** ADDR_W));

   assign last_k = (k_cnt == t_r - TAP_W'(1));
   assign last_n = ({1'b0, n_cnt} == n_r - (ADDR_W+1)'(1));
   assign last_c = (c_cnt == c_r - CH_W'(1));
   assign in_mac = (state == S_MAC);

   // Taps reaching before the channel start read the channel base and are masked.
   assign k_ext   = ADDR_W'(k_cnt);
   assign mask    = (n_cnt < k_ext);
   assign smp_off = mask ? '0 : n_cnt - k_ext;

   assign bus.coef_addr = in_mac ? coef_base + CA_W'(k_cnt) : '0;
   assign bus.smp_addr  = in_mac ? smp_base + smp_off : '0;
   assign bus.res_we    = (state == S_WRITE);
   assign bus.res_addr  = (state == S_WRITE) ? res_ptr : '0;
   assign bus.res_wdata = (state == S_WRITE) ? rs_dout : '0;
   assign bus.busy      = (state == S_MAC) || (state == S_DRAIN) || (state == S_WRITE);
   assign bus.done      = (state == S_DONE) || (state == S_ERR);
   assign bus.err       = err_r;
   assign bus.sat       = sat_r;

   fir_round_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_round_sat (
      .acc   (acc),
      .shift (sh_r),
      .dout  (rs_dout),
      .sat   (rs_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         t_r       <= '0;
         n_r       <= '0;
         c_r       <= '0;
         sh_r      <= '0;
         k_cnt     <= '0;
         n_cnt     <= '0;
         c_cnt     <= '0;
         smp_base  <= '0;
         coef_base <= '0;
         res_ptr   <= '0;
         drain_cnt <= 1'b0;
         p1_vld    <= 1'b0;
         p1_mask   <= 1'b0;
         p1_first  <= 1'b0;
         p2_vld    <= 1'b0;
         p2_first  <= 1'b0;
         prod      <= '0;
         acc       <= '0;
         err_r     <= 1'b0;
         sat_r     <= 1'b0;
      end else begin
         // Stage 1: memory read in flight; stage 2: registered product.
         p1_vld   <= in_mac;
         p1_mask  <= mask;
         p1_first <= (k_cnt == '0);
         p2_vld   <= p1_vld;
         p2_first <= p1_first;
         if (p1_mask) prod <= '0;
         else         prod <= bus.coef_rdata * bus.smp_rdata;
         if (p2_vld)
            acc <= (p2_first ? '0 : acc) + {{(ACC_W-PRD_W){prod[PRD_W-1]}}, prod};

         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  t_r       <= bus.cfg_taps;
                  n_r       <= bus.cfg_samples;
                  c_r       <= bus.cfg_channels;
                  sh_r      <= bus.cfg_shift;
                  k_cnt     <= '0;
                  n_cnt     <= '0;
                  c_cnt     <= '0;
                  smp_base  <= '0;
                  coef_base <= '0;
                  res_ptr   <= '0;
                  drain_cnt <= 1'b0;
                  err_r     <= 1'b0;
                  sat_r     <= 1'b0;
                  state     <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (cfg_bad) begin
                  err_r <= 1'b1;
                  state <= S_ERR;
               end else begin
                  state <= S_MAC;
               end
            end
            S_MAC: begin
               if (last_k) begin
                  k_cnt <= '0;
                  state <= S_DRAIN;
               end else begin
                  k_cnt <= k_cnt + TAP_W'(1);
               end
            end
            S_DRAIN: begin
               drain_cnt <= ~drain_cnt;
               if (drain_cnt) state <= S_WRITE;
            end
            S_WRITE: begin
               res_ptr <= res_ptr + ADDR_W'(1);
               if (rs_sat) sat_r <= 1'b1;
               if (last_n) begin
                  n_cnt     <= '0;
                  c_cnt     <= c_cnt + CH_W'(1);
                  smp_base  <= smp_base + n_r[ADDR_W-1:0];
                  coef_base <= coef_base + CA_W'(MAX_TAPS);
                  state     <= last_c ? S_DONE : S_MAC;
               end else begin
                  n_cnt <= n_cnt + ADDR_W'(1);
                  state <= S_MAC;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mc_engine.sv
// Directed bench for fir_mc_engine: table of batch vectors plus hand-written
// config-error, reset-mid-batch and start-while-busy sequences.
module tb_fir_mc_engine;
   import fir_pkg::*;

   localparam int DATA_W   = 16;
   localparam int COEF_W   = 16;
   localparam int MAX_TAPS = 32;
   localparam int MAX_CH   = 4;
   localparam int ADDR_W   = 13;
   localparam int TAP_W    = $clog2(MAX_TAPS + 1);
   localparam int CH_W     = $clog2(MAX_CH + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fir_mc_engine_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .MAX_TAPS(MAX_TAPS),
                      .MAX_CH(MAX_CH), .ADDR_W(ADDR_W)) bus ();

   fir_mc_engine #(.DATA_W(DATA_W), .COEF_W(COEF_W), .MAX_TAPS(MAX_TAPS),
                   .MAX_CH(MAX_CH), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] coef_mem [0:127];
   logic [15:0] smp_mem  [0:8191];
   logic [15:0] got_y    [0:8191];

   // Synchronous-read memories: data one cycle after the address.
   always @(posedge clk) begin
      bus.coef_rdata <= coef_mem[bus.coef_addr];
      bus.smp_rdata  <= smp_mem[bus.smp_addr];
   end

   typedef struct packed {
      logic [7:0]        t;
      logic [7:0]        n;
      logic [7:0]        c;
      logic [7:0]        sh;
      logic [7:0][15:0]  h;   // h[c*4+k]
      logic [7:0][15:0]  x;   // channel-packed samples
      logic [7:0][15:0]  y;   // expected results
      logic              sat;
   } vec_t;

   vec_t vt [4];
   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic load_case(input int i);
      for (int a = 0; a < 128; a++) coef_mem[a] = 16'h0;
      for (int a = 0; a < 16; a++) begin
         smp_mem[a] = 16'h0;
         got_y[a]   = 16'hBEEF;
      end
      for (int c = 0; c < 2; c++)
         for (int k = 0; k < 4; k++) coef_mem[c*32+k] = vt[i].h[c*4+k];
      for (int j = 0; j < 8; j++) smp_mem[j] = vt[i].x[j];
   endtask

   // Starts a batch, returns at the negedge of the done cycle (or after the budget).
   task automatic run_batch(input int t, input int n, input int c, input int sh,
                            input int poke, input bit exp_busy,
                            output int done_cyc, output int we_cnt,
                            output int busy_bad, output bit err_v, output bit sat_v);
      @(negedge clk);
      bus.cfg_taps     = TAP_W'(t);
      bus.cfg_samples  = (ADDR_W+1)'(n);
      bus.cfg_channels = CH_W'(c);
      bus.cfg_shift    = 6'(sh);
      bus.start        = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      done_cyc = -1; we_cnt = 0; busy_bad = 0; err_v = 1'b0; sat_v = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (bus.res_we) begin
            got_y[bus.res_addr] = bus.res_wdata;
            chk("res_we_cycle", cyc, (we_cnt + 1) * (t + 3));
            chk("res_addr_order", longint'(bus.res_addr), we_cnt);
            we_cnt++;
         end
         if (bus.done) begin
            done_cyc = cyc;
            err_v    = bus.err;
            sat_v    = bus.sat;
            if (bus.busy) busy_bad++;
            break;
         end
         if (bus.busy !== (exp_busy && cyc >= 1)) busy_bad++;
         // Captured config must be immune to later changes.
         if (cyc == 0) begin
            bus.cfg_taps     = '0;
            bus.cfg_samples  = '0;
            bus.cfg_channels = '0;
            bus.cfg_shift    = 6'd63;
         end
         bus.start = (cyc == poke);
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   task automatic run_case(input int i, input int poke);
      int  dc, wc, bb;
      bit  ev, sv;
      load_case(i);
      run_batch(int'(vt[i].t), int'(vt[i].n), int'(vt[i].c), int'(vt[i].sh), poke, 1'b1,
                dc, wc, bb, ev, sv);
      chk($sformatf("case%0d_done_cycle", i), dc,
          int'(vt[i].c) * int'(vt[i].n) * (int'(vt[i].t) + 3) + 1);
      chk($sformatf("case%0d_we_count", i), wc, int'(vt[i].c) * int'(vt[i].n));
      chk($sformatf("case%0d_busy", i), bb, 0);
      chk($sformatf("case%0d_err", i), ev, 0);
      chk($sformatf("case%0d_sat", i), sv, vt[i].sat);
      for (int j = 0; j < int'(vt[i].c) * int'(vt[i].n); j++)
         chk($sformatf("case%0d_y%0d", i, j), got_y[j], vt[i].y[j]);
      @(negedge clk);
      chk($sformatf("case%0d_sat_held", i), bus.sat, vt[i].sat);
      chk($sformatf("case%0d_idle_busy", i), bus.busy, 0);
   endtask

   int et [3][3] = '{'{0, 4, 1}, '{4, 4, MAX_CH + 1}, '{1, 4096, 4}};

   initial begin
      int  dc, wc, bb, cnt;
      bit  ev, sv;
      rst = 1'b1;
      bus.start = 1'b0; bus.cfg_taps = '0; bus.cfg_samples = '0;
      bus.cfg_channels = '0; bus.cfg_shift = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {bus.coef_addr, bus.smp_addr, bus.res_addr, bus.res_wdata,
                            bus.res_we, bus.busy, bus.done, bus.err, bus.sat}, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) vt[i] = '0;
      // impulse response
      vt[0].t = 4; vt[0].n = 6; vt[0].c = 1; vt[0].sh = 0;
      vt[0].h[0] = 16'd1; vt[0].h[1] = 16'd2; vt[0].h[2] = 16'd3; vt[0].h[3] = 16'd4;
      vt[0].x[0] = 16'd1;
      vt[0].y[0] = 16'd1; vt[0].y[1] = 16'd2; vt[0].y[2] = 16'd3; vt[0].y[3] = 16'd4;
      // two channels
      vt[1].t = 2; vt[1].n = 3; vt[1].c = 2; vt[1].sh = 0;
      vt[1].h[0] = 16'd1; vt[1].h[1] = 16'd1; vt[1].h[4] = 16'd1; vt[1].h[5] = 16'hFFFF;
      vt[1].x[0] = 16'd1; vt[1].x[1] = 16'd2; vt[1].x[2] = 16'd3;
      vt[1].x[3] = 16'd5; vt[1].x[4] = 16'd7; vt[1].x[5] = 16'd4;
      vt[1].y[0] = 16'd1; vt[1].y[1] = 16'd3; vt[1].y[2] = 16'd5;
      vt[1].y[3] = 16'd5; vt[1].y[4] = 16'd2; vt[1].y[5] = 16'hFFFD;
      // rounding
      vt[2].t = 1; vt[2].n = 2; vt[2].c = 1; vt[2].sh = 15;
      vt[2].h[0] = 16'h4000; vt[2].x[0] = 16'd3; vt[2].x[1] = 16'hFFFD;
      vt[2].y[0] = 16'd2; vt[2].y[1] = 16'hFFFF;
      // saturation
      vt[3].t = 2; vt[3].n = 2; vt[3].c = 1; vt[3].sh = 0;
      vt[3].h[0] = 16'h7FFF; vt[3].h[1] = 16'h7FFF;
      vt[3].x[0] = 16'h7FFF; vt[3].x[1] = 16'h7FFF;
      vt[3].y[0] = 16'(DEF_SAT_MAX); vt[3].y[1] = 16'(DEF_SAT_MAX); vt[3].sat = 1'b1;

      for (int i = 0; i < 4; i++) run_case(i, -1);

      // Configuration errors; the first also shows sat cleared by the accept.
      for (int e = 0; e < 3; e++) begin
         run_batch(et[e][0], et[e][1], et[e][2], 0, -1, 1'b0, dc, wc, bb, ev, sv);
         chk($sformatf("err%0d_done_cycle", e), dc, 1);
         chk($sformatf("err%0d_err", e), ev, 1);
         chk($sformatf("err%0d_we_count", e), wc, 0);
         chk($sformatf("err%0d_busy", e), bb, 0);
         if (e == 0) chk("sat_cleared_on_start", sv, 0);
         @(negedge clk);
         chk($sformatf("err%0d_err_held", e), bus.err, 1);
      end

      // Reset in cycle 10 of the impulse batch.
      load_case(0);
      @(negedge clk);
      bus.cfg_taps = TAP_W'(4); bus.cfg_samples = (ADDR_W+1)'(6);
      bus.cfg_channels = CH_W'(1); bus.cfg_shift = 6'd0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      chk("busy_before_rst", bus.busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("outputs_after_rst", {bus.coef_addr, bus.smp_addr, bus.res_addr, bus.res_wdata,
                                bus.res_we, bus.busy, bus.done, bus.err, bus.sat}, 0);
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.res_we || bus.done || bus.busy) cnt++;
      end
      chk("no_activity_after_rst", cnt, 0);

      // Start while busy is ignored; a fresh batch afterwards completes.
      run_case(0, 5);
      run_case(1, -1);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
